// File: rtl/demodulador.sv
// -----------------------------------------------------------------------------
// demodulador
//
// Receive-side companion of the sine-sample modulator. Recovers bits from an
// 8-bit unsigned sine stream (mid-scale MID) and reassembles them LSB-first
// into bytes.
//
// Symbol coding: bit 0 is one full sine period per symbol, bit 1 is one
// half-period per symbol (polarity alternating). The first and second halves
// of each symbol are therefore of opposite polarity for a 0 and of equal
// polarity for a 1. That comparison does not depend on absolute polarity, so
// no phase tracking is needed.
//
// Ports:
//   clk            rising-edge clock
//   rst_n          asynchronous active-low reset
//   amostra        unsigned input sample
//   amostra_valida qualifies amostra; samples are consumed only when 1
//   sync           alignment pulse; the sample accepted with it is index 0
//                  of bit 0 of a new byte
//   dado_rx        last completed byte, held until the next one completes
//   byte_valido    one-cycle pulse when dado_rx updates
//   bit_rx         last decided bit
//   bit_valido     one-cycle pulse when bit_rx updates
//   sincronizado   high once a sync has been seen, cleared only by reset
// -----------------------------------------------------------------------------
module demodulador #(
    parameter int SAMPLES_PER_BIT = 32,
    parameter int MID             = 128,
    parameter int BITS_PER_BYTE   = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [7:0]               amostra,
    input  logic                     amostra_valida,
    input  logic                     sync,
    output logic [BITS_PER_BYTE-1:0] dado_rx,
    output logic                     byte_valido,
    output logic                     bit_rx,
    output logic                     bit_valido,
    output logic                     sincronizado
);

    localparam int H      = SAMPLES_PER_BIT / 2;
    localparam int IDX_W  = $clog2(SAMPLES_PER_BIT);
    localparam int ACC_W  = $clog2(H);
    localparam int BCNT_W = (BITS_PER_BYTE > 1) ? $clog2(BITS_PER_BYTE) : 1;

    localparam logic [7:0]        MID_L     = 8'(MID);
    localparam logic [IDX_W-1:0]  IDX_ZERO  = '0;
    localparam logic [IDX_W-1:0]  IDX_ONE   = IDX_W'(1);
    localparam logic [IDX_W-1:0]  IDX_H     = IDX_W'(H);
    localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(SAMPLES_PER_BIT - 1);
    localparam logic [ACC_W:0]    HALF_THR  = (ACC_W + 1)'(H / 2);
    localparam logic [BCNT_W-1:0] BCNT_LAST = BCNT_W'(BITS_PER_BYTE - 1);

    // Only two modes: waiting for the first sync, and locked to symbol timing.
    typedef enum logic {
        ST_IDLE,
        ST_SYNC
    } state_t;

    state_t                   state,        state_n;
    logic [IDX_W-1:0]         idx,          idx_n;
    logic [ACC_W-1:0]         acc_a,        acc_a_n;
    logic [ACC_W-1:0]         acc_b,        acc_b_n;
    logic [BCNT_W-1:0]        bitcnt,       bitcnt_n;
    logic [BITS_PER_BYTE-1:0] shreg,        shreg_n;
    logic [BITS_PER_BYTE-1:0] dado_rx_n;
    logic                     bit_rx_n;
    logic                     bit_valido_n;
    logic                     byte_valido_n;

    logic                     above;
    logic [ACC_W:0]           b_total;
    logic                     a_hi;
    logic                     b_hi;
    logic                     bit_dec;

    // Strictly greater: a sample sitting exactly on MID counts as not-above.
    assign above = (amostra > MID_L);

    // The decision sample (last index) belongs to the second half, so it is
    // folded into acc_b before the threshold compare.
    assign b_total = {1'b0, acc_b} + (ACC_W + 1)'(above);
    assign a_hi    = ({1'b0, acc_a} >= HALF_THR);
    assign b_hi    = (b_total >= HALF_THR);
    assign bit_dec = (a_hi == b_hi);

    assign sincronizado = (state == ST_SYNC);

    // NOTE: every variable gets its hold/default value first so that no path
    // through the branches below leaves one unassigned (which would infer a latch).
    always_comb begin
        state_n       = state;
        idx_n         = idx;
        acc_a_n       = acc_a;
        acc_b_n       = acc_b;
        bitcnt_n      = bitcnt;
        shreg_n       = shreg;
        dado_rx_n     = dado_rx;
        bit_rx_n      = bit_rx;
        bit_valido_n  = 1'b0;
        byte_valido_n = 1'b0;

        if (sync) begin
            // Realign: the partial byte is dropped without a byte pulse.
            state_n  = ST_SYNC;
            idx_n    = amostra_valida ? IDX_ONE : IDX_ZERO;
            acc_a_n  = '0;
            acc_b_n  = '0;
            bitcnt_n = '0;
            shreg_n  = '0;
        end else if (state == ST_SYNC && amostra_valida) begin
            // Power-of-two symbol length: the increment wraps on its own.
            idx_n = idx + IDX_ONE;

            // Indices 0 and H are nominal zero crossings and are skipped.
            if (idx != IDX_ZERO && idx < IDX_H) begin
                acc_a_n = acc_a + ACC_W'(above);
            end else if (idx > IDX_H && idx != IDX_LAST) begin
                acc_b_n = acc_b + ACC_W'(above);
            end

            if (idx == IDX_LAST) begin
                acc_a_n         = '0;
                acc_b_n         = '0;
                bit_rx_n        = bit_dec;
                bit_valido_n    = 1'b1;
                shreg_n[bitcnt] = bit_dec;
                if (bitcnt == BCNT_LAST) begin
                    bitcnt_n      = '0;
                    dado_rx_n     = shreg_n;
                    byte_valido_n = 1'b1;
                end else begin
                    bitcnt_n = bitcnt + BCNT_W'(1);
                end
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ST_IDLE;
            idx         <= '0;
            acc_a       <= '0;
            acc_b       <= '0;
            bitcnt      <= '0;
            shreg       <= '0;
            dado_rx     <= '0;
            bit_rx      <= 1'b0;
            bit_valido  <= 1'b0;
            byte_valido <= 1'b0;
        end else begin
            state       <= state_n;
            idx         <= idx_n;
            acc_a       <= acc_a_n;
            acc_b       <= acc_b_n;
            bitcnt      <= bitcnt_n;
            shreg       <= shreg_n;
            dado_rx     <= dado_rx_n;
            bit_rx      <= bit_rx_n;
            bit_valido  <= bit_valido_n;
            byte_valido <= byte_valido_n;
        end
    end

endmodule

// File: doc/demodulador.md
Name: demodulador

Overview:
- Receive-side stage that sits directly downstream of the sine-sample modulator.
- Consumes the 8-bit unsigned sine sample stream (mid-scale 128) and recovers the transmitted bits.
- Symbol encoding: bit 0 is one full sine period per symbol; bit 1 is one half-period per symbol, with polarity alternating from symbol to symbol.
- Bits are reassembled LSB-first into bytes, and each completed byte is presented with a one-cycle valid strobe.

Parameters:
- SAMPLES_PER_BIT, 32, samples per symbol. Power of two, >= 8. Sets the index counter width to log2(SAMPLES_PER_BIT).
- MID, 128, mid-scale threshold. A sample counts as "above" only when strictly greater than MID.
- BITS_PER_BYTE, 8, bits assembled per output byte.

Ports:
- clk  in  1  Rising-edge clock.
- rst_n  in  1  Reset, asynchronous, active-low.
- amostra  in  8  Unsigned input sample.
- amostra_valida  in  1  Qualifies amostra. A sample is consumed only in cycles where this is 1.
- sync  in  1  Symbol/byte alignment pulse. The sample accepted in the same cycle is symbol index 0 of bit 0.
- dado_rx  out  8  Last completed byte. Held stable until the next byte completes.
- byte_valido  out  1  One-cycle pulse when dado_rx updates.
- bit_rx  out  1  Last decided bit.
- bit_valido  out  1  One-cycle pulse when bit_rx updates.
- sincronizado  out  1  High once a sync has been seen. Cleared only by reset.

Behaviour:
- Reset (rst_n=0, asynchronous): all outputs 0; idx, bit counter, accumulators and shift register cleared; sincronizado=0.
- Idle: while sincronizado=0, samples are ignored and all counters hold.
- sync=1:
  - Sets sincronizado, clears the bit counter and accumulators, and sets idx=0.
  - If amostra_valida=1 in that cycle, that sample is index 0 and idx advances to 1.
  - Any partial byte is discarded; no byte_valido pulse is produced for it.
  - sync takes priority over all other per-cycle updates.
- Accepted sample (sincronizado=1, amostra_valida=1, sync=0): processed at index idx, then idx increments. idx wraps from SAMPLES_PER_BIT-1 to 0.
- amostra_valida=0: idx, accumulators and counters hold. Gaps have no effect on decisions.
- Accumulators, with H = SAMPLES_PER_BIT/2:
  - acc_a counts samples > MID at indices 1..H-1.
  - acc_b counts samples > MID at indices H+1..2H-1.
  - Indices 0 and H are ignored; they are nominal zero crossings.
  - Each accumulator is log2(H) bits wide and cannot overflow.
- Decision, taken when the sample at index 2H-1 is accepted:
  - a_hi = (acc_a >= H/2), b_hi = (acc_b >= H/2), both including the current sample.
  - bit = (a_hi == b_hi): same polarity in both halves means bit 1; opposite polarity means bit 0.
  - The decision is independent of the modulator's alternating polarity, so no phase tracking is needed.
- Decision cycle updates (registered, visible on the next clock edge):
  - bit_rx = bit; bit_valido pulses for one cycle.
  - bit is written to shift-register position bitcnt (LSB first); bitcnt increments.
  - acc_a and acc_b clear.
- Byte completion: when bitcnt = BITS_PER_BYTE-1 at the decision:
  - dado_rx loads the full byte in the same edge as bit_rx.
  - byte_valido pulses for one cycle.
  - bitcnt wraps to 0.
- Latency: byte_valido is asserted exactly one clock after the 256th accepted sample counted from the sync sample (defaults, no gaps).
- Back-to-back bytes need no idle samples between them. Byte pulses are spaced exactly SAMPLES_PER_BIT*BITS_PER_BYTE accepted samples apart.
- Samples equal to MID count as not-above. Up to H/2-1 corrupted samples per half-symbol are tolerated.

Test Plan:
- Reset: drive rst_n=0 mid-run, then release -> all outputs 0, sincronizado=0. Then 100 valid samples with no sync -> no bit_valido or byte_valido.
- Single byte: sync plus an ideal modulator waveform for 0xA5, amostra_valida=1 continuously -> bit_valido pulses 8 times, 32 cycles apart, with bit_rx sequence 1,0,1,0,0,1,0,1. byte_valido pulses once, 256 cycles after the sync cycle, with dado_rx=0xA5.
- Back-to-back: waveforms for 0x00, 0xFF, 0x3C without gaps -> three byte_valido pulses 256 cycles apart with those values. dado_rx holds between pulses.
- Valid gaps: 0x5A with amostra_valida toggling every cycle -> dado_rx=0x5A, pulse 512 cycles after sync. No extra or missing bit_valido pulses.
- Noise: 0xC3 with 3 samples per half-symbol forced across MID, and samples at indices 0 and 16 forced to 0 -> dado_rx=0xC3.
- Resync: sync re-asserted after 100 samples of a byte, then 0x81 sent -> no pulse for the partial byte; next byte_valido carries 0x81, 256 cycles after the new sync.
